// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl: builds a 16-bit hex guess one nibble at a time, scores it
// with the downstream checker's combinational result during a one-cycle CHECK
// state, counts attempts and declares the round won or lost.
//
// Pulse semantics: start, clear and enter are single-cycle, level-sampled on
// the rising clock edge with priority start > clear > enter; score_valid is a
// one-cycle pulse aligned with the update of last_correct/last_wrong/tries_used.
module guess_round_ctrl #(
    parameter int MAX_TRIES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        clear,
    input  logic        enter,
    input  logic [3:0]  digit_in,
    input  logic [3:0]  correct_digits,
    input  logic [3:0]  wrong_place_digits,
    output logic [15:0] user_guess,
    output logic [1:0]  digit_idx,
    output logic [3:0]  last_correct,
    output logic [3:0]  last_wrong,
    output logic [3:0]  tries_used,
    output logic        score_valid,
    output logic        busy,
    output logic        won,
    output logic        lost
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_WON   = 3'd3;
    localparam logic [2:0] S_LOST  = 3'd4;

    localparam logic [3:0] MAX_TRIES_4 = 4'(MAX_TRIES);

    logic [2:0]  state;
    logic [15:0] guess_wr;
    logic [3:0]  tries_next;

    // Guess with digit_in written into the nibble selected by digit_idx (0 = MSB)
    always_comb begin
        guess_wr = user_guess;
        case (digit_idx)
            2'd0:    guess_wr[15:12] = digit_in;
            2'd1:    guess_wr[11:8]  = digit_in;
            2'd2:    guess_wr[7:4]   = digit_in;
            default: guess_wr[3:0]   = digit_in;
        endcase
    end

    assign tries_next = tries_used + 4'd1;

    // Round state machine plus all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            user_guess   <= '0;
            digit_idx    <= '0;
            last_correct <= '0;
            last_wrong   <= '0;
            tries_used   <= '0;
            score_valid  <= 1'b0;
        end else begin
            score_valid <= 1'b0;
            if (start) begin
                // A restart wins over everything, including a pending score
                state      <= S_ENTRY;
                user_guess <= '0;
                digit_idx  <= '0;
                tries_used <= '0;
            end else begin
                case (state)
                    S_ENTRY: begin
                        if (clear) begin
                            user_guess <= '0;
                            digit_idx  <= '0;
                        end else if (enter) begin
                            user_guess <= guess_wr;
                            digit_idx  <= digit_idx + 2'd1;
                            if (digit_idx == 2'd3) begin
                                state <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        // user_guess is stable here, so the checker result is valid
                        last_correct <= correct_digits;
                        last_wrong   <= wrong_place_digits;
                        tries_used   <= tries_next;
                        score_valid  <= 1'b1;
                        if (correct_digits == 4'd4) begin
                            state <= S_WON;
                        end else if (tries_next == MAX_TRIES_4) begin
                            state <= S_LOST;
                        end else begin
                            state <= S_ENTRY;
                        end
                    end
                    default: begin
                        // IDLE, WON, LOST hold until start
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign busy = (state == S_ENTRY) || (state == S_CHECK);
    assign won  = (state == S_WON);
    assign lost = (state == S_LOST);

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Bench for guess_round_ctrl with a behavioural stand-in for the digit checker
// (secret 0xA3C5); the checker result can be overridden to inject odd values.
module tb_guess_round_ctrl;

    localparam logic [15:0] SECRET = 16'hA3C5;

    typedef struct packed {
        logic [15:0] guess;
        logic [1:0]  idx;
        logic [3:0]  lc;
        logic [3:0]  lw;
        logic [3:0]  tries;
        logic        sv;
        logic        busy;
        logic        won;
        logic        lost;
    } exp_t;

    typedef struct packed {
        logic       st;
        logic       cl;
        logic       en;
        logic [3:0] d;
        exp_t       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic        enter = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic [3:0]  correct_digits;
    logic [3:0]  wrong_place_digits;
    logic [15:0] user_guess;
    logic [1:0]  digit_idx;
    logic [3:0]  last_correct;
    logic [3:0]  last_wrong;
    logic [3:0]  tries_used;
    logic        score_valid;
    logic        busy;
    logic        won;
    logic        lost;

    logic        ovr_en = 1'b0;
    logic [3:0]  ovr_c = 4'd0;
    logic [3:0]  ovr_w = 4'd0;

    int n_vec = 0;
    int n_err = 0;
    vec_t vq[$];

    guess_round_ctrl #(.MAX_TRIES(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .clear(clear),
        .enter(enter),
        .digit_in(digit_in),
        .correct_digits(correct_digits),
        .wrong_place_digits(wrong_place_digits),
        .user_guess(user_guess),
        .digit_idx(digit_idx),
        .last_correct(last_correct),
        .last_wrong(last_wrong),
        .tries_used(tries_used),
        .score_valid(score_valid),
        .busy(busy),
        .won(won),
        .lost(lost)
    );

    // Clock
    always #5 clk = ~clk;

    // Checker model: exact-position matches, then common digits not in place
    function automatic logic [7:0] score(input logic [15:0] g);
        int cg[16];
        int cs[16];
        int c;
        int common;
        logic [15:0] s;
        s = SECRET;
        c = 0;
        common = 0;
        for (int v = 0; v < 16; v++) begin
            cg[v] = 0;
            cs[v] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (g[4*i +: 4] == s[4*i +: 4]) c++;
            cg[g[4*i +: 4]]++;
            cs[s[4*i +: 4]]++;
        end
        for (int v = 0; v < 16; v++) begin
            common += (cg[v] < cs[v]) ? cg[v] : cs[v];
        end
        return {4'(c), 4'(common - c)};
    endfunction

    always_comb begin
        if (ovr_en) begin
            correct_digits     = ovr_c;
            wrong_place_digits = ovr_w;
        end else begin
            {correct_digits, wrong_place_digits} = score(user_guess);
        end
    end

    // Compare every output against one expected record
    task automatic check(input string tag, input exp_t e);
        n_vec++;
        if (user_guess !== e.guess) begin
            n_err++; $display("FAIL %s user_guess got %h exp %h", tag, user_guess, e.guess);
        end
        if (digit_idx !== e.idx) begin
            n_err++; $display("FAIL %s digit_idx got %0d exp %0d", tag, digit_idx, e.idx);
        end
        if (last_correct !== e.lc) begin
            n_err++; $display("FAIL %s last_correct got %0d exp %0d", tag, last_correct, e.lc);
        end
        if (last_wrong !== e.lw) begin
            n_err++; $display("FAIL %s last_wrong got %0d exp %0d", tag, last_wrong, e.lw);
        end
        if (tries_used !== e.tries) begin
            n_err++; $display("FAIL %s tries_used got %0d exp %0d", tag, tries_used, e.tries);
        end
        if (score_valid !== e.sv) begin
            n_err++; $display("FAIL %s score_valid got %b exp %b", tag, score_valid, e.sv);
        end
        if (busy !== e.busy) begin
            n_err++; $display("FAIL %s busy got %b exp %b", tag, busy, e.busy);
        end
        if (won !== e.won) begin
            n_err++; $display("FAIL %s won got %b exp %b", tag, won, e.won);
        end
        if (lost !== e.lost) begin
            n_err++; $display("FAIL %s lost got %b exp %b", tag, lost, e.lost);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1 after the rising edge
    task automatic step(input logic st, input logic cl, input logic en, input logic [3:0] d);
        @(negedge clk);
        start = st;
        clear = cl;
        enter = en;
        digit_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic st, input logic cl, input logic en, input logic [3:0] d,
                       input logic [15:0] g, input logic [1:0] idx, input logic [3:0] lc,
                       input logic [3:0] lw, input logic [3:0] tr, input logic sv,
                       input logic bz, input logic wn, input logic ls);
        vec_t v;
        v.st = st; v.cl = cl; v.en = en; v.d = d;
        v.e = '{guess: g, idx: idx, lc: lc, lw: lw, tries: tr, sv: sv, busy: bz, won: wn, lost: ls};
        vq.push_back(v);
    endtask

    function automatic exp_t mk(input logic [15:0] g, input logic [1:0] idx, input logic [3:0] lc,
                                input logic [3:0] lw, input logic [3:0] tr, input logic sv,
                                input logic bz, input logic wn, input logic ls);
        return '{guess: g, idx: idx, lc: lc, lw: lw, tries: tr, sv: sv, busy: bz, won: wn, lost: ls};
    endfunction

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Test sequence
    initial begin
        //  st cl en d     guess     idx lc lw tr sv bz wn ls
        add(1, 0, 0, 4'h0, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0);  // start
        add(0, 0, 1, 4'hA, 16'hA000, 1, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 4'h3, 16'hA300, 2, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 4'hC, 16'hA3C0, 3, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 4'h5, 16'hA3C5, 0, 0, 0, 0, 0, 1, 0, 0);  // now CHECK
        add(0, 0, 0, 4'h0, 16'hA3C5, 0, 4, 0, 1, 1, 0, 1, 0);  // scored: win
        add(0, 0, 0, 4'h0, 16'hA3C5, 0, 4, 0, 1, 0, 0, 1, 0);  // pulse falls
        add(0, 0, 1, 4'hF, 16'hA3C5, 0, 4, 0, 1, 0, 0, 1, 0);  // enter ignored in WON
        add(0, 1, 0, 4'h0, 16'hA3C5, 0, 4, 0, 1, 0, 0, 1, 0);  // clear ignored in WON
        add(1, 0, 0, 4'h0, 16'h0000, 0, 4, 0, 0, 0, 1, 0, 0);  // restart, last_* kept
        add(0, 0, 1, 4'h5, 16'h5000, 1, 4, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 4'hC, 16'h5C00, 2, 4, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 4'hA, 16'h5CA0, 3, 4, 0, 0, 0, 1, 0, 0);
        add(0, 0, 1, 4'h3, 16'h5CA3, 0, 4, 0, 0, 0, 1, 0, 0);  // CHECK
        add(0, 0, 0, 4'h0, 16'h5CA3, 0, 0, 4, 1, 1, 1, 0, 0);  // misplaced, back to ENTRY
        add(0, 0, 1, 4'h1, 16'h1CA3, 1, 0, 4, 1, 0, 1, 0, 0);  // only MSB nibble replaced
        add(0, 0, 1, 4'hA, 16'h1AA3, 2, 0, 4, 1, 0, 1, 0, 0);
        add(0, 1, 0, 4'h0, 16'h0000, 0, 0, 4, 1, 0, 1, 0, 0);  // clear
        add(0, 0, 1, 4'h7, 16'h7000, 1, 0, 4, 1, 0, 1, 0, 0);
        add(0, 1, 1, 4'hF, 16'h0000, 0, 0, 4, 1, 0, 1, 0, 0);  // clear beats enter
        add(0, 0, 1, 4'h2, 16'h2000, 1, 0, 4, 1, 0, 1, 0, 0);
        add(1, 0, 1, 4'hF, 16'h0000, 0, 0, 4, 0, 0, 1, 0, 0);  // start beats enter
        add(1, 1, 0, 4'h0, 16'h0000, 0, 0, 4, 0, 0, 1, 0, 0);  // start beats clear

        // Reset state, checked while reset is held
        #2;
        check("reset", mk(16'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 4'h9);
        check("idle_enter_ignored", mk(16'h0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Table
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].st, vq[i].cl, vq[i].en, vq[i].d);
            check($sformatf("vec%0d", i), vq[i].e);
        end

        // Loss after eight all-zero guesses
        step(1, 0, 0, 4'h0);
        for (int t = 1; t <= 8; t++) begin
            for (int k = 0; k < 4; k++) step(0, 0, 1, 4'h0);
            check($sformatf("loss_check%0d", t), mk(16'h0, 0, 0, (t == 1) ? 4'd4 : 4'd0,
                  4'(t - 1), 0, 1, 0, 0));
            step(0, 0, 0, 4'h0);
            check($sformatf("loss_score%0d", t), mk(16'h0, 0, 0, 0, 4'(t), 1, (t != 8), 0, (t == 8)));
        end
        for (int k = 0; k < 5; k++) step(0, 0, 1, 4'(k + 3));
        check("lost_hold", mk(16'h0, 0, 0, 0, 8, 0, 0, 0, 1));

        // Out-of-range checker result is latched as-is and is not a win
        ovr_en = 1'b1; ovr_c = 4'd5; ovr_w = 4'd7;
        step(1, 0, 0, 4'h0);
        step(0, 0, 1, 4'h1);
        step(0, 0, 1, 4'h2);
        step(0, 0, 1, 4'h3);
        step(0, 0, 1, 4'h4);
        step(0, 0, 0, 4'h0);
        check("c5_not_win", mk(16'h1234, 0, 5, 7, 1, 1, 1, 0, 0));
        ovr_en = 1'b0;

        // start during CHECK aborts scoring
        step(1, 0, 0, 4'h0);
        step(0, 0, 1, 4'hA);
        step(0, 0, 1, 4'h3);
        step(0, 0, 1, 4'hC);
        step(0, 0, 1, 4'h5);
        check("abort_in_check", mk(16'hA3C5, 0, 5, 7, 0, 0, 1, 0, 0));
        step(1, 0, 0, 4'h0);
        check("abort_edge", mk(16'h0, 0, 5, 7, 0, 0, 1, 0, 0));
        step(0, 0, 0, 4'h0);
        check("abort_after", mk(16'h0, 0, 5, 7, 0, 0, 1, 0, 0));

        // Asynchronous reset mid-entry
        step(0, 0, 1, 4'hA);
        step(0, 0, 1, 4'h3);
        check("pre_reset", mk(16'hA300, 2, 5, 7, 0, 0, 1, 0, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", mk(16'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 4'hB);
        check("post_reset_enter", mk(16'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1, 0, 0, 4'h0);
        step(0, 0, 1, 4'hB);
        check("post_reset_start", mk(16'hB000, 1, 0, 0, 0, 0, 1, 0, 0));

        step(0, 0, 0, 4'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
